// File: rtl/can_crc_check_if.sv
// ---------------------------------------------------------------------------
// can_crc_check_if
// Bundle between the bit destuffer / RX frame controller and the CAN CRC
// checker.
//   din, bit_en, frame_start, abort   : destuffed bit stream and control (to checker)
//   busy, done                        : frame-in-progress flag and completion pulse
//   crc_ok, crc_err, form_err         : held result flags
//   calc_crc, rx_crc, dlc             : computed CRC, received CRC, raw DLC
// Modports: master = bit source / frame controller, slave = checker.
// ---------------------------------------------------------------------------
interface can_crc_check_if;
  logic        din;
  logic        bit_en;
  logic        frame_start;
  logic        abort;
  logic        busy;
  logic        done;
  logic        crc_ok;
  logic        crc_err;
  logic        form_err;
  logic [14:0] calc_crc;
  logic [14:0] rx_crc;
  logic [3:0]  dlc;

  modport master (
    output din, bit_en, frame_start, abort,
    input  busy, done, crc_ok, crc_err, form_err, calc_crc, rx_crc, dlc
  );

  modport slave (
    input  din, bit_en, frame_start, abort,
    output busy, done, crc_ok, crc_err, form_err, calc_crc, rx_crc, dlc
  );
endinterface

// File: rtl/can_crc_check.sv
// ---------------------------------------------------------------------------
// can_crc_check
// Receive-side CAN 2.0 CRC-15 checker. It follows the destuffed bit stream
// from SOF, parses the header to find RTR/DLC, runs the CRC-15 LFSR over
// SOF..end-of-data, captures the 15 received CRC bits, compares them and
// checks the CRC delimiter.
//
// Ports
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : can_crc_check_if.slave
//            in : din, bit_en, frame_start, abort
//            out: busy, done, crc_ok, crc_err, form_err, calc_crc, rx_crc, dlc
//
// Parameters
//   POLY      : CRC-15 generator polynomial (x^15 term implicit)
//   MAX_BYTES : data byte cap; larger DLC values are clamped to it
//
// Configuration macro
//   CAN_EXT_FRAME_EN : when defined, IDE=1 selects the 39-bit extended header.
//                      When undefined, an IDE=1 bit ends the frame with form_err.
// ---------------------------------------------------------------------------
module can_crc_check #(
  parameter logic [14:0] POLY      = 15'h4599,
  parameter int          MAX_BYTES = 8
) (
  input logic            clk,
  input logic            rst_n,
  can_crc_check_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_CRC,
    ST_DELIM
  } state_t;

  // Header bit positions, SOF being position 0.
  localparam logic [6:0] LP_RTR_STD_IDX = 7'd12;
  localparam logic [6:0] LP_IDE_IDX     = 7'd13;
  localparam logic [6:0] LP_STD_LAST    = 7'd18;
  localparam logic [6:0] LP_EXT_LAST    = 7'd38;
`ifdef CAN_EXT_FRAME_EN
  localparam logic [6:0] LP_RTR_EXT_IDX = 7'd32;
`endif
  localparam logic [3:0] LP_MAX_BYTES   = 4'(MAX_BYTES);

  state_t      r_state,    w_state_next;
  logic [6:0]  r_cnt,      w_cnt_next;
  logic [14:0] r_lfsr,     w_lfsr_next;
  logic [14:0] r_calc_crc, w_calc_crc_next;
  logic [14:0] r_rx_crc,   w_rx_crc_next;
  logic [3:0]  r_dlc,      w_dlc_next;
  logic        r_rtr,      w_rtr_next;
  logic        r_ide,      w_ide_next;
  logic        r_done,     w_done_next;
  logic        r_crc_ok,   w_crc_ok_next;
  logic        r_crc_err,  w_crc_err_next;
  logic        r_form_err, w_form_err_next;

  logic [14:0] w_lfsr_step;
  logic [14:0] w_lfsr_sof;
  logic [3:0]  w_dlc_full;
  logic [3:0]  w_bytes;
  logic [6:0]  w_data_bits;
  logic [6:0]  w_hdr_last;

  function automatic logic [14:0] lfsr_step(input logic [14:0] s, input logic b);
    logic fb;
    fb = b ^ s[14];
    return {s[13:0], 1'b0} ^ (fb ? POLY : 15'd0);
  endfunction

  assign w_lfsr_step = lfsr_step(r_lfsr, bus.din);
  // A new frame starts from a cleared LFSR with the SOF bit already clocked in.
  assign w_lfsr_sof  = lfsr_step(15'd0, bus.din);

  // DLC including the bit currently on din; only meaningful on the last DLC bit.
  assign w_dlc_full  = {r_dlc[2:0], bus.din};
  assign w_bytes     = (w_dlc_full > LP_MAX_BYTES) ? LP_MAX_BYTES : w_dlc_full;
  assign w_data_bits = r_rtr ? 7'd0 : {w_bytes, 3'b000};
  // r_ide can only be 1 past the IDE bit when the extended header is enabled.
  assign w_hdr_last  = r_ide ? LP_EXT_LAST : LP_STD_LAST;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_lfsr     <= '0;
      r_calc_crc <= '0;
      r_rx_crc   <= '0;
      r_dlc      <= '0;
      r_rtr      <= 1'b0;
      r_ide      <= 1'b0;
      r_done     <= 1'b0;
      r_crc_ok   <= 1'b0;
      r_crc_err  <= 1'b0;
      r_form_err <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_lfsr     <= w_lfsr_next;
      r_calc_crc <= w_calc_crc_next;
      r_rx_crc   <= w_rx_crc_next;
      r_dlc      <= w_dlc_next;
      r_rtr      <= w_rtr_next;
      r_ide      <= w_ide_next;
      r_done     <= w_done_next;
      r_crc_ok   <= w_crc_ok_next;
      r_crc_err  <= w_crc_err_next;
      r_form_err <= w_form_err_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_lfsr_next     = r_lfsr;
    w_calc_crc_next = r_calc_crc;
    w_rx_crc_next   = r_rx_crc;
    w_dlc_next      = r_dlc;
    w_rtr_next      = r_rtr;
    w_ide_next      = r_ide;
    w_done_next     = 1'b0;
    w_crc_ok_next   = r_crc_ok;
    w_crc_err_next  = r_crc_err;
    w_form_err_next = r_form_err;

    if (bus.abort) begin
      // Abort wins over a simultaneous frame_start.
      w_state_next    = ST_IDLE;
      w_crc_ok_next   = 1'b0;
      w_crc_err_next  = 1'b0;
      w_form_err_next = 1'b0;
    end else if (bus.bit_en && bus.frame_start) begin
      // SOF from any state; a frame in progress is dropped silently.
      w_state_next    = ST_HDR;
      w_cnt_next      = 7'd1;
      w_lfsr_next     = w_lfsr_sof;
      w_dlc_next      = '0;
      w_rtr_next      = 1'b0;
      w_ide_next      = 1'b0;
      w_crc_ok_next   = 1'b0;
      w_crc_err_next  = 1'b0;
      w_form_err_next = 1'b0;
    end else if (bus.bit_en) begin
      case (r_state)
        ST_IDLE: begin
          // Bits outside a frame are ignored.
        end

        ST_HDR: begin
          w_lfsr_next = w_lfsr_step;
          w_cnt_next  = r_cnt + 7'd1;
          if (r_cnt == LP_RTR_STD_IDX) begin
            // In an extended header this is SRR; the real RTR overwrites it later.
            w_rtr_next = bus.din;
          end
          if (r_cnt == LP_IDE_IDX) begin
            w_ide_next = bus.din;
`ifndef CAN_EXT_FRAME_EN
            if (bus.din) begin
              w_form_err_next = 1'b1;
              w_done_next     = 1'b1;
              w_state_next    = ST_IDLE;
            end
`endif
          end
`ifdef CAN_EXT_FRAME_EN
          if (r_ide && (r_cnt == LP_RTR_EXT_IDX)) begin
            w_rtr_next = bus.din;
          end
`endif
          if (r_cnt >= (w_hdr_last - 7'd3)) begin
            w_dlc_next = w_dlc_full;
          end
          if (r_cnt == w_hdr_last) begin
            if (w_data_bits != 7'd0) begin
              w_state_next = ST_DATA;
              w_cnt_next   = w_data_bits;
            end else begin
              w_state_next    = ST_CRC;
              w_cnt_next      = '0;
              w_calc_crc_next = w_lfsr_step;
              w_rx_crc_next   = '0;
            end
          end
        end

        ST_DATA: begin
          // r_cnt holds the number of data bits still to come, including this one.
          w_lfsr_next = w_lfsr_step;
          if (r_cnt == 7'd1) begin
            w_state_next    = ST_CRC;
            w_cnt_next      = '0;
            w_calc_crc_next = w_lfsr_step;
            w_rx_crc_next   = '0;
          end else begin
            w_cnt_next = r_cnt - 7'd1;
          end
        end

        ST_CRC: begin
          w_rx_crc_next = {r_rx_crc[13:0], bus.din};
          w_cnt_next    = r_cnt + 7'd1;
          if (r_cnt == 7'd14) begin
            w_state_next = ST_DELIM;
          end
        end

        ST_DELIM: begin
          w_crc_err_next  = (r_rx_crc != r_calc_crc);
          w_form_err_next = ~bus.din;
          w_crc_ok_next   = (r_rx_crc == r_calc_crc) & bus.din;
          w_done_next     = 1'b1;
          w_state_next    = ST_IDLE;
        end

        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.done     = r_done;
  assign bus.crc_ok   = r_crc_ok;
  assign bus.crc_err  = r_crc_err;
  assign bus.form_err = r_form_err;
  assign bus.calc_crc = r_calc_crc;
  assign bus.rx_crc   = r_rx_crc;
  assign bus.dlc      = r_dlc;

endmodule
